// File: rtl/msrv_32_dmem_arbiter_if.sv
// Load/store-unit and AHB-lite data-memory signals of the msrv_32 data-memory arbiter.
// The arbiter uses the slave modport. The load/store units and memory side use the master modport.
interface msrv_32_dmem_arbiter_if;
    logic        ld_req_in;
    logic [31:0] ld_addr_in;
    logic        st_req_in;
    logic [31:0] st_addr_in;
    logic [31:0] st_data_in;
    logic [3:0]  st_mask_in;
    logic        ahb_ready_in;
    logic        ahb_resp_in;
    logic [31:0] ahb_rdata_in;
    logic [1:0]  ahb_htrans_out;
    logic [31:0] ms_riscv32_mp_dmadder_out;
    logic        ms_riscv32_mp_dmwr_req_out;
    logic [31:0] ms_riscv32_mp_dmdata_out;
    logic [3:0]  ms_riscv32_mp_dmwr_mask_out;
    logic        ld_ack_out;
    logic [31:0] ld_rdata_out;
    logic        st_ack_out;
    logic        err_out;
    logic        busy_out;

    modport slave (
        input  ld_req_in, ld_addr_in, st_req_in, st_addr_in, st_data_in, st_mask_in,
        input  ahb_ready_in, ahb_resp_in, ahb_rdata_in,
        output ahb_htrans_out, ms_riscv32_mp_dmadder_out, ms_riscv32_mp_dmwr_req_out,
        output ms_riscv32_mp_dmdata_out, ms_riscv32_mp_dmwr_mask_out,
        output ld_ack_out, ld_rdata_out, st_ack_out, err_out, busy_out
    );

    modport master (
        output ld_req_in, ld_addr_in, st_req_in, st_addr_in, st_data_in, st_mask_in,
        output ahb_ready_in, ahb_resp_in, ahb_rdata_in,
        input  ahb_htrans_out, ms_riscv32_mp_dmadder_out, ms_riscv32_mp_dmwr_req_out,
        input  ms_riscv32_mp_dmdata_out, ms_riscv32_mp_dmwr_mask_out,
        input  ld_ack_out, ld_rdata_out, st_ack_out, err_out, busy_out
    );
endinterface

// File: rtl/msrv_32_dmem_arbiter.sv
// Shares the msrv_32 AHB-lite data port between the load and store units.
// Each transfer has a non-overlapped address phase and data phase.
// Define MSRV32_DMEM_TIMEOUT_EN to abort a phase that waits TIMEOUT_CYCLES cycles.
module msrv_32_dmem_arbiter #(
    parameter int unsigned FIXED_PRI      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                          ms_riscv32_mp_clk_in,
    input  logic                          ms_riscv32_mp_rst_in,
    msrv_32_dmem_arbiter_if.slave         bus
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..255");
    end

    state_e      state_q;
    logic        last_st_q;
    logic        gnt_st_q;
    logic [31:0] wdata_lat_q;
    logic [3:0]  mask_lat_q;
    logic [1:0]  htrans_q;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [31:0] hwdata_q;
    logic [3:0]  hmask_q;
    logic        ld_ack_q;
    logic        st_ack_q;
    logic        err_q;
    logic [31:0] ld_rdata_q;
    logic        busy_q;

    logic pick_st;
    logic data_done;
    logic timeout_hit;
    logic xfer_end;
    logic xfer_err;

    // Round-robin favours the unit not served last; fixed priority always favours the load.
    assign pick_st = bus.st_req_in &&
                     (!bus.ld_req_in || (FIXED_PRI == 0 && !last_st_q));

    assign data_done = (state_q == StData) && bus.ahb_ready_in;

`ifdef MSRV32_DMEM_TIMEOUT_EN
    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    logic [7:0] wait_cnt_q;

    // The wait that takes the count to TimeoutLimit is the one that aborts.
    assign timeout_hit = (state_q == StAddr || state_q == StData) && !bus.ahb_ready_in &&
                         (wait_cnt_q == TimeoutLimit - 8'd1);

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            wait_cnt_q <= 8'd0;
        end else if (state_q == StIdle || bus.ahb_ready_in) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign xfer_end = data_done || timeout_hit;
    assign xfer_err = (data_done && bus.ahb_resp_in) || timeout_hit;

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q     <= StIdle;
            last_st_q   <= 1'b1;
            gnt_st_q    <= 1'b0;
            wdata_lat_q <= 32'd0;
            mask_lat_q  <= 4'd0;
            htrans_q    <= HtransIdle;
            haddr_q     <= 32'd0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= 32'd0;
            hmask_q     <= 4'd0;
            ld_ack_q    <= 1'b0;
            st_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            ld_rdata_q  <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            ld_ack_q <= 1'b0;
            st_ack_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.ld_req_in || bus.st_req_in) begin
                        gnt_st_q    <= pick_st;
                        last_st_q   <= pick_st;
                        wdata_lat_q <= pick_st ? bus.st_data_in : 32'd0;
                        mask_lat_q  <= pick_st ? bus.st_mask_in : 4'd0;
                        htrans_q    <= HtransNonseq;
                        haddr_q     <= pick_st ? bus.st_addr_in : bus.ld_addr_in;
                        hwrite_q    <= pick_st;
                        busy_q      <= 1'b1;
                        state_q     <= StAddr;
                    end
                end
                StAddr: begin
                    if (bus.ahb_ready_in) begin
                        htrans_q <= HtransIdle;
                        hwdata_q <= wdata_lat_q;
                        hmask_q  <= mask_lat_q;
                        state_q  <= StData;
                    end
                end
                StData: begin
                    if (bus.ahb_ready_in && !gnt_st_q) begin
                        ld_rdata_q <= bus.ahb_rdata_in;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Common completion path for both a normal data phase and a timeout abort.
            if (xfer_end) begin
                htrans_q <= HtransIdle;
                hwrite_q <= 1'b0;
                hwdata_q <= 32'd0;
                hmask_q  <= 4'd0;
                ld_ack_q <= !gnt_st_q;
                st_ack_q <= gnt_st_q;
                err_q    <= xfer_err;
                busy_q   <= 1'b0;
                state_q  <= StIdle;
            end
        end
    end

    assign bus.ahb_htrans_out              = htrans_q;
    assign bus.ms_riscv32_mp_dmadder_out   = haddr_q;
    assign bus.ms_riscv32_mp_dmwr_req_out  = hwrite_q;
    assign bus.ms_riscv32_mp_dmdata_out    = hwdata_q;
    assign bus.ms_riscv32_mp_dmwr_mask_out = hmask_q;
    assign bus.ld_ack_out                  = ld_ack_q;
    assign bus.ld_rdata_out                = ld_rdata_q;
    assign bus.st_ack_out                  = st_ack_q;
    assign bus.err_out                     = err_q;
    assign bus.busy_out                    = busy_q;

endmodule

// File: doc/msrv_32_dmem_arbiter.md
Name: msrv_32_dmem_arbiter

Overview:
Sequences and shares the single AHB-lite data-memory port of the msrv_32 core between the load unit and the store unit.
- Accepts one request from each unit and grants one at a time (round-robin or fixed priority).
- Runs a non-overlapped address-phase / data-phase transfer, then returns load data or a store acknowledge to the granted unit.
- Sits between the load/store units and the ms_riscv32_mp_dm* / ahb_* memory interface.

Parameters:
FIXED_PRI, 0, 0 = round-robin on simultaneous requests; 1 = load always wins.
TIMEOUT_CYCLES, 16, wait-state limit per phase (used only with MSRV32_DMEM_TIMEOUT_EN).

Ports:
ms_riscv32_mp_clk_in  input  1  clock, rising edge
ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-low
ld_req_in  input  1  load request, held until ld_ack_out
ld_addr_in  input  32  load address
st_req_in  input  1  store request, held until st_ack_out
st_addr_in  input  32  store address (already aligned by store unit)
st_data_in  input  32  store data (already lane-shifted)
st_mask_in  input  4  byte write mask
ahb_ready_in  input  1  HREADY
ahb_resp_in  input  1  HRESP (1 = error)
ahb_rdata_in  input  32  HRDATA
ahb_htrans_out  output  2  HTRANS (00 IDLE, 10 NONSEQ)
ms_riscv32_mp_dmadder_out  output  32  HADDR
ms_riscv32_mp_dmwr_req_out  output  1  HWRITE
ms_riscv32_mp_dmdata_out  output  32  HWDATA
ms_riscv32_mp_dmwr_mask_out  output  4  write mask
ld_ack_out  output  1  one-cycle pulse: load done
ld_rdata_out  output  32  captured load data, held until next load completes
st_ack_out  output  1  one-cycle pulse: store done
err_out  output  1  one-cycle pulse, coincident with the ack, on error/timeout
busy_out  output  1  1 whenever state != IDLE (pipeline stall)

Behaviour:
- Reset (asynchronous, active-low): state = IDLE, last_grant = STORE, all outputs = 0. An in-flight transfer is dropped with no ack. Reset is released synchronously into IDLE.
- All outputs are registered.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any request is present, grant one and latch its addr/data/mask/direction.
  - htrans <= 10, dmadder <= addr, dmwr_req <= (grant == store).
  - Go to ADDR.
  - No request: stay in IDLE, htrans = 00.
- Arbitration on simultaneous requests:
  - FIXED_PRI = 0: grant the unit that is not last_grant. last_grant updates on every grant.
  - FIXED_PRI = 1: load wins.
- ADDR:
  - Hold htrans/addr/write while ahb_ready_in = 0.
  - On ready = 1: htrans <= 00, dmdata/mask <= latched values (zeros for a load), go to DATA.
- DATA:
  - Hold while ready = 0.
  - On ready = 1:
    - Load: ld_rdata_out <= ahb_rdata_in.
    - Pulse the granted ack.
    - err_out pulse if ahb_resp_in = 1.
    - Clear dmwr_req, dmdata and mask.
    - Go to IDLE.
- Latency with zero wait states: request seen in cycle 0, NONSEQ visible in cycle 1, data phase in cycle 2, ack in cycle 3. Each wait state adds 1 cycle.
- Request lifetime:
  - A request dropped before grant is ignored.
  - Request changes after grant are ignored, because the payload is latched.
  - A request still high in the ack cycle is a new request, granted from IDLE on the next edge.
- No back-to-back overlap: every transfer returns to IDLE for at least one cycle.

Optional Feature:
Macro: MSRV32_DMEM_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on each state entry and increments while ready = 0 in ADDR or DATA.
  - When the counter reaches TIMEOUT_CYCLES: abort, pulse the granted ack and err_out, set htrans = 00, clear write outputs, go to IDLE.
  - A load abort leaves ld_rdata_out unchanged.
- Not defined: the counter logic is absent and the FSM waits indefinitely for ready.

Test Plan:
1. Store addr 0x12345678, data 0x0000EF01, mask 0x3, ready = 1 -> cycle 1: htrans = 10, addr = 0x12345678, dmwr_req = 1. Cycle 2: dmdata = 0x0000EF01, mask = 0x3. Cycle 3: st_ack = 1, err = 0.
2. Load addr 0x00001004, ready low for 2 cycles in DATA, rdata 0xDEADBEEF -> ld_ack in cycle 5, ld_rdata_out = 0xDEADBEEF, dmwr_req = 0 throughout.
3. FIXED_PRI = 0, ld_req and st_req both high after reset and held -> load granted first, store second. Repeat -> store first. FIXED_PRI = 1 -> load always first.
4. Store with ahb_resp_in = 1 in the DATA ready cycle -> st_ack and err_out pulse together, FSM returns to IDLE.
5. Reset asserted mid-DATA of a load -> all outputs 0 immediately (asynchronously), no ld_ack. After release, htrans = 00 until a new request.
6. Macro defined, TIMEOUT_CYCLES = 16, ready held 0 in ADDR -> ld_ack and err_out pulse after 16 wait cycles, ld_rdata_out unchanged. Macro undefined -> the FSM waits in ADDR indefinitely.
